// File: rtl/acorn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acorn_pkg
//  Description : Shared phase encodings and step-count constants for ACORN-128
//  Revision    : 1.0
// ============================================================================
package acorn_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_AD    = 3'd2,
        PH_ENC   = 3'd3,
        PH_FINAL = 3'd4
    } phase_t;

    localparam int STEP_W      = 11;
    localparam int INIT_STEPS  = 1792;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_BITS    = 128;
    localparam int PAD_STEPS   = 256;

endpackage
`default_nettype wire

// File: rtl/acorn_step_decode.sv
`default_nettype none
// ============================================================================
//  Module      : acorn_step_decode
//  Description : Combinational decode of (phase, step, operands) to ca/cb/m
//                and ciphertext/tag qualifiers
//  Revision    : 1.0
// ============================================================================
module acorn_step_decode
    import acorn_pkg::*;
#(
    parameter int AD_LEN    = 128,
    parameter int PT_LEN    = 128,
    parameter int TAG_START = 640
) (
    input  phase_t        phase,
    input  logic [10:0]   step,
    input  logic [127:0]  key,
    input  logic [127:0]  iv,
    input  logic [1023:0] ad,
    input  logic [1023:0] pt,
    output logic          ca,
    output logic          cb,
    output logic          mbit,
    output logic          ct_valid,
    output logic          tag_valid
);

    localparam logic [10:0] C_AD_LEN    = 11'(AD_LEN);
    localparam logic [10:0] C_AD_CA_END = 11'(AD_LEN + TAG_BITS);
    localparam logic [10:0] C_PT_LEN    = 11'(PT_LEN);
    localparam logic [10:0] C_PT_CA_END = 11'(PT_LEN + TAG_BITS);
    localparam logic [10:0] C_TAG_START = 11'(TAG_START);

    always_comb begin
        ca        = 1'b0;
        cb        = 1'b0;
        mbit      = 1'b0;
        ct_valid  = 1'b0;
        tag_valid = 1'b0;
        case (phase)
            PH_INIT: begin
                ca = 1'b1;
                cb = 1'b1;
                // key, then IV, then one inverted key[0], then key repeating mod 128
                if (step < 11'd128)
                    mbit = key[step[6:0]];
                else if (step < 11'd256)
                    mbit = iv[step[6:0]];
                else if (step == 11'd256)
                    mbit = ~key[0];
                else
                    mbit = key[step[6:0]];
            end
            PH_AD: begin
                ca = (step < C_AD_CA_END);
                cb = 1'b1;
                if (step < C_AD_LEN)
                    mbit = ad[step[9:0]];
                else
                    mbit = (step == C_AD_LEN);
            end
            PH_ENC: begin
                ca       = (step < C_PT_CA_END);
                ct_valid = (step < C_PT_LEN);
                if (step < C_PT_LEN)
                    mbit = pt[step[9:0]];
                else
                    mbit = (step == C_PT_LEN);
            end
            PH_FINAL: begin
                ca        = 1'b1;
                cb        = 1'b1;
                tag_valid = (step >= C_TAG_START);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acorn_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : acorn_phase_ctrl
//  Description : ACORN-128 step sequencer: phase FSM, step counter, operand
//                latches and per-step control bit decode
//  Revision    : 1.0
// ============================================================================
module acorn_phase_ctrl #(
    parameter int AD_LEN      = 128,
    parameter int PT_LEN      = 128,
    parameter int INIT_STEPS  = acorn_pkg::INIT_STEPS,
    parameter int FINAL_STEPS = acorn_pkg::FINAL_STEPS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic [127:0]  key_in,
    input  logic [127:0]  iv_in,
    input  logic [1023:0] ad_in,
    input  logic [1023:0] pt_in,
    output logic          busy,
    output logic          done,
    output logic [2:0]    phase_o,
    output logic [10:0]   step_o,
    output logic          step_valid,
    output logic          ca_out,
    output logic          cb_out,
    output logic          mbit_out,
    output logic          ct_valid,
    output logic          tag_valid
);
    import acorn_pkg::*;

    localparam logic [10:0] C_INIT_LAST  = 11'(INIT_STEPS - 1);
    localparam logic [10:0] C_AD_LAST    = 11'(AD_LEN + PAD_STEPS - 1);
    localparam logic [10:0] C_ENC_LAST   = 11'(PT_LEN + PAD_STEPS - 1);
    localparam logic [10:0] C_FINAL_LAST = 11'(FINAL_STEPS - 1);

    phase_t         r_phase;
    logic [10:0]    r_step;
    logic           r_busy;
    logic           r_done;
    logic [127:0]   r_key;
    logic [127:0]   r_iv;
    logic [1023:0]  r_ad;
    logic [1023:0]  r_pt;
    logic [10:0]    w_last;

    always_comb begin
        w_last = C_FINAL_LAST;
        case (r_phase)
            PH_INIT: w_last = C_INIT_LAST;
            PH_AD:   w_last = C_AD_LAST;
            PH_ENC:  w_last = C_ENC_LAST;
            default: w_last = C_FINAL_LAST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_key   <= '0;
            r_iv    <= '0;
            r_ad    <= '0;
            r_pt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_phase == PH_IDLE) begin
                if (start) begin
                    r_phase <= PH_INIT;
                    r_step  <= '0;
                    r_busy  <= 1'b1;
                    r_key   <= key_in;
                    r_iv    <= iv_in;
                    r_ad    <= ad_in;
                    r_pt    <= pt_in;
                end
            end else if (!stall) begin
                if (r_step == w_last) begin
                    r_step <= '0;
                    case (r_phase)
                        PH_INIT: r_phase <= PH_AD;
                        PH_AD:   r_phase <= PH_ENC;
                        PH_ENC:  r_phase <= PH_FINAL;
                        default: begin
                            r_phase <= PH_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    endcase
                end else begin
                    r_step <= r_step + 11'd1;
                end
            end
        end
    end

    acorn_step_decode #(
        .AD_LEN    (AD_LEN),
        .PT_LEN    (PT_LEN),
        .TAG_START (FINAL_STEPS - TAG_BITS)
    ) u_decode (
        .phase     (r_phase),
        .step      (r_step),
        .key       (r_key),
        .iv        (r_iv),
        .ad        (r_ad),
        .pt        (r_pt),
        .ca        (ca_out),
        .cb        (cb_out),
        .mbit      (mbit_out),
        .ct_valid  (ct_valid),
        .tag_valid (tag_valid)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign phase_o = r_phase;
    assign step_o  = r_step;
    // stall gates step_valid directly so the consumer sees the hold in the same cycle
    assign step_valid = r_busy & ~stall & (r_phase != PH_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acorn_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acorn_phase_ctrl
//  Description : Self-checking bench for acorn_phase_ctrl against a step-index
//                reference model
//  Revision    : 1.0
// ============================================================================
module tb_acorn_phase_ctrl;

    localparam int AD_LEN = 128;
    localparam int PT_LEN = 128;
    localparam int N_INIT = 1792;
    localparam int N_AD   = AD_LEN + 256;
    localparam int N_ENC  = PT_LEN + 256;
    localparam int N_FIN  = 768;
    localparam int TOTAL  = N_INIT + N_AD + N_ENC + N_FIN;

    logic          clk = 1'b0;
    logic          rst, start, stall;
    logic [127:0]  key_in, iv_in;
    logic [1023:0] ad_in, pt_in;
    logic          busy, done, step_valid, ca_out, cb_out, mbit_out, ct_valid, tag_valid;
    logic [2:0]    phase_o;
    logic [10:0]   step_o;
    logic [21:0]   dut_vec;

    logic [127:0]  m_key, m_iv;
    logic [1023:0] m_ad, m_pt;
    int checks = 0;
    int errors = 0;

    acorn_phase_ctrl #(
        .AD_LEN (AD_LEN),
        .PT_LEN (PT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .key_in     (key_in),
        .iv_in      (iv_in),
        .ad_in      (ad_in),
        .pt_in      (pt_in),
        .busy       (busy),
        .done       (done),
        .phase_o    (phase_o),
        .step_o     (step_o),
        .step_valid (step_valid),
        .ca_out     (ca_out),
        .cb_out     (cb_out),
        .mbit_out   (mbit_out),
        .ct_valid   (ct_valid),
        .tag_valid  (tag_valid)
    );

    always #5 clk = ~clk;

    assign dut_vec = {phase_o, step_o, busy, done, step_valid,
                      ca_out, cb_out, mbit_out, ct_valid, tag_valid};

    // Expected outputs when k steps of the run have been consumed.
    function automatic logic [21:0] model_vec(input int k, input bit stl);
        int ph = 0, st = 0;
        bit ca = 0, cb = 0, m = 0, ct = 0, tg = 0, bz, dn = 0;
        if (k < N_INIT) begin
            ph = 1; st = k; ca = 1; cb = 1;
            if (st < 128)       m = m_key[st];
            else if (st < 256)  m = m_iv[st - 128];
            else if (st == 256) m = !m_key[0];
            else                m = m_key[st % 128];
        end else if (k < N_INIT + N_AD) begin
            ph = 2; st = k - N_INIT; ca = (st < AD_LEN + 128); cb = 1;
            m = (st < AD_LEN) ? m_ad[st] : (st == AD_LEN);
        end else if (k < N_INIT + N_AD + N_ENC) begin
            ph = 3; st = k - N_INIT - N_AD; ca = (st < PT_LEN + 128); cb = 0;
            m = (st < PT_LEN) ? m_pt[st] : (st == PT_LEN);
            ct = (st < PT_LEN);
        end else if (k < TOTAL) begin
            ph = 4; st = k - N_INIT - N_AD - N_ENC; ca = 1; cb = 1;
            tg = (st >= N_FIN - 128);
        end else begin
            dn = 1;
        end
        bz = (k < TOTAL);
        return {3'(ph), 11'(st), bz, dn, bz && !stl, ca, cb, m, ct, tg};
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            key_in[i*32 +: 32] = $urandom();
            iv_in[i*32 +: 32]  = $urandom();
        end
        for (int i = 0; i < 32; i++) begin
            ad_in[i*32 +: 32] = $urandom();
            pt_in[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (dut_vec !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, 22'd0);
        end
    endtask

    // Operands change after acceptance so the run only sees latched values.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        m_key = key_in; m_iv = iv_in; m_ad = ad_in; m_pt = pt_in;
        @(posedge clk);
        #1 start = 1'b0;
        randomize_inputs();
    endtask

    task automatic run_checked(input int stall_mode, input bit poke_start, input bit restart,
                               output int cycles, output int tags, output int stalls);
        int  k = 0;
        int  stall_left = 5;
        bit  finished = 0;
        cycles = -1; tags = 0; stalls = 0;
        for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
            @(negedge clk);
            case (stall_mode)
                0:       stall = 1'b0;
                1:       stall = ($urandom_range(0, 9) == 0);
                default: stall = (k == N_INIT + N_AD - 1) && (stall_left > 0);
            endcase
            if (stall_mode == 2 && stall) stall_left--;
            start = poke_start && (k == 10);
            #1;
            checks++;
            if (dut_vec !== model_vec(k, stall)) begin
                errors++;
                $display("FAIL run_step cyc=%0d k=%0d: got %h expected %h",
                         cyc, k, dut_vec, model_vec(k, stall));
            end
            if (tag_valid && step_valid) tags++;
            if (k == TOTAL) begin
                cycles = cyc;
                finished = 1;
                if (restart) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                    @(negedge clk); #1;
                    checks++;
                    if ({phase_o, step_o, busy} !== {3'd1, 11'd0, 1'b1}) begin
                        errors++;
                        $display("FAIL restart_in_done: got ph=%0d step=%0d busy=%b expected ph=1 step=0 busy=1",
                                 phase_o, step_o, busy);
                    end
                end
            end else if (!stall) begin
                k++;
            end else begin
                stalls++;
            end
        end
        start = 1'b0; stall = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL run_timeout: got no done, expected done after %0d steps", TOTAL);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_full_run();
        int c, t, s;
        do_reset(); randomize_inputs(); do_start();
        run_checked(0, 0, 0, c, t, s);
        checks++;
        if (c !== TOTAL) begin
            errors++; $display("FAIL full_run_length: got %0d expected %0d", c, TOTAL);
        end
        checks++;
        if (t !== 128) begin
            errors++; $display("FAIL tag_count: got %0d expected 128", t);
        end
    endtask

    task automatic test_random_stall();
        int c, t, s;
        do_reset(); randomize_inputs(); do_start();
        run_checked(1, 0, 0, c, t, s);
        checks++;
        if (c !== TOTAL + s) begin
            errors++; $display("FAIL stalled_run_length: got %0d expected %0d", c, TOTAL + s);
        end
        checks++;
        if (t !== 128) begin
            errors++; $display("FAIL stalled_tag_count: got %0d expected 128", t);
        end
    endtask

    task automatic test_stall_ad_last();
        int c, t, s;
        do_reset(); randomize_inputs(); do_start();
        run_checked(2, 0, 0, c, t, s);
        checks++;
        if (c !== TOTAL + 5) begin
            errors++; $display("FAIL ad_stall_length: got %0d expected %0d", c, TOTAL + 5);
        end
    endtask

    task automatic test_start_ignored();
        int c, t, s;
        do_reset(); randomize_inputs(); do_start();
        run_checked(0, 1, 0, c, t, s);
    endtask

    task automatic test_back_to_back();
        int c, t, s;
        do_reset(); randomize_inputs(); do_start();
        run_checked(1, 0, 1, c, t, s);
    endtask

    task automatic test_init_vectors();
        bit m;
        do_reset(); randomize_inputs();
        key_in = 128'h1; iv_in = '0;
        do_start();
        for (int k = 0; k <= 384; k++) begin
            @(negedge clk); #1;
            if (k == 0 || k == 1 || k == 256 || k == 384) begin
                m = (k == 0 || k == 384);
                checks++;
                if ({phase_o, step_o, ca_out, cb_out, mbit_out} !== {3'd1, 11'(k), 1'b1, 1'b1, m}) begin
                    errors++;
                    $display("FAIL init_vector k=%0d: got ph=%0d step=%0d ca=%b cb=%b m=%b expected ph=1 step=%0d ca=1 cb=1 m=%b",
                             k, phase_o, step_o, ca_out, cb_out, mbit_out, k, m);
                end
            end
        end
    endtask

    task automatic test_enc_vectors();
        bit       reached = 0;
        logic [3:0] exp;
        do_reset(); randomize_inputs();
        pt_in = 1024'd1;
        do_start();
        for (int cyc = 0; cyc < 3000 && !reached; cyc++) begin
            @(negedge clk); #1;
            if (phase_o == 3'd3 && (step_o == 0 || step_o == 128 || step_o == 255 || step_o == 256)) begin
                case (step_o)
                    11'd0:   exp = 4'b1011;
                    11'd128: exp = 4'b1010;
                    11'd255: exp = 4'b1000;
                    default: exp = 4'b0000;
                endcase
                checks++;
                if ({ca_out, cb_out, mbit_out, ct_valid} !== exp) begin
                    errors++;
                    $display("FAIL enc_vector step=%0d: got ca,cb,m,ct=%b expected %b",
                             step_o, {ca_out, cb_out, mbit_out, ct_valid}, exp);
                end
                if (step_o == 11'd256) reached = 1;
            end
        end
        if (!reached) begin
            checks++; errors++;
            $display("FAIL enc_timeout: got no ENC step 256, expected it within 3000 cycles");
        end
    endtask

    task automatic test_reset_mid_enc();
        bit hit = 0;
        int pulses = 0;
        do_reset(); randomize_inputs(); do_start();
        for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
            @(negedge clk); #1;
            if (phase_o == 3'd3 && step_o == 11'd50) hit = 1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (!hit || dut_vec !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid_enc: got hit=%b outputs %h expected hit=1 outputs %h", hit, dut_vec, 22'd0);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL reset_no_done: got %0d done pulses expected 0", pulses);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        randomize_inputs();
        test_reset();
        test_init_vectors();
        test_enc_vectors();
        test_full_run();
        test_random_stall();
        test_stall_ad_last();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_enc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
